// File: rtl/calc_pkg.sv
// Shared types, widths and the response ALU for the calculator port responder.
package calc_pkg;

  localparam int DATA_W  = 32;
  localparam int TAG_W   = 2;
  localparam int CMD_W   = 4;
  localparam int RESP_W  = 2;
  localparam int ENTRY_W = RESP_W + DATA_W + TAG_W;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } state_e;

  // Buffered response; field order matches {out_resp, out_data, out_tag}.
  typedef struct packed {
    logic [RESP_W-1:0] resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  // Evaluates one command; error responses always carry zero data.
  function automatic entry_t calc_alu(input logic [CMD_W-1:0]  cmd,
                                      input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b,
                                      input logic [TAG_W-1:0]  tag);
    entry_t          r;
    logic [DATA_W:0] sum;
    r.tag  = tag;
    r.resp = RESP_ERR;
    r.data = 32'd0;
    sum    = {1'b0, a} + {1'b0, b};
    case (cmd)
      CMD_ADD: begin
        if (sum[DATA_W]) begin
          r.resp = RESP_ERR;
          r.data = 32'd0;
        end else begin
          r.resp = RESP_OK;
          r.data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (b > a) begin
          r.resp = RESP_ERR;
          r.data = 32'd0;
        end else begin
          r.resp = RESP_OK;
          r.data = a - b;
        end
      end
      CMD_SHL: begin
        r.resp = RESP_OK;
        r.data = a << b[4:0];
      end
      CMD_SHR: begin
        r.resp = RESP_OK;
        r.data = a >> b[4:0];
      end
      default: begin
        r.resp = RESP_ERR;
        r.data = 32'd0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_resp_fifo.sv
// Response buffer: circular FIFO of DEPTH entries with occupancy count.
// The caller never pushes when full; a push and a pop in the same cycle
// leave the count unchanged.
module calc_resp_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_push,
  input  logic [ENTRY_W-1:0]            i_entry,
  input  logic                          i_pop,
  output logic [ENTRY_W-1:0]            o_head,
  output logic [$clog2(DEPTH):0]        o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // Storage write; contents are don't-care until pushed so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/calc_port_responder.sv
// Two-cycle command port: command+operand 1, then operand 2. Results are
// buffered and presented one per cycle while the consumer is not stalling.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  input  logic              out_stall,
  output logic [RESP_W-1:0] out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              req_busy
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PEND_W = CNT_W + 1;

  state_e            r_state;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_op1;
  logic [TAG_W-1:0]  r_tag;

  logic              w_push;
  logic              w_pop;
  entry_t            w_entry;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic [PEND_W-1:0] w_pending;

  // The request in OP2 is pushed at the coming edge, so it already holds a slot.
  always_comb begin
    w_push    = (r_state == ST_OP2);
    w_pop     = !out_stall && (w_count != CNT_W'(0));
    w_entry   = calc_alu(r_cmd, r_op1, req_data_in, r_tag);
    w_pending = {1'b0, w_count} + {{CNT_W{1'b0}}, w_push};
  end

  assign req_busy = (w_pending >= PEND_W'(FIFO_DEPTH));

  // Input FSM: capture command, operand 1 and tag, then finish on operand 2.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cmd   <= 4'd0;
      r_op1   <= 32'd0;
      r_tag   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((req_cmd_in != 4'd0) && !req_busy) begin
            r_cmd   <= req_cmd_in;
            r_op1   <= req_data_in;
            r_tag   <= req_tag_in;
            r_state <= ST_OP2;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_OP2:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  calc_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (c_clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Output stage: present each popped entry for exactly one cycle, else zeros.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      out_resp <= 2'd0;
      out_data <= 32'd0;
      out_tag  <= 2'd0;
    end else if (w_pop) begin
      {out_resp, out_data, out_tag} <= w_head;
    end else begin
      out_resp <= 2'd0;
      out_data <= 32'd0;
      out_tag  <= 2'd0;
    end
  end

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed self-checking bench for calc_port_responder.
module tb_calc_port_responder;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic        out_stall;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        req_busy;

  int errors = 0;
  int checks = 0;

  calc_port_responder #(.FIFO_DEPTH(4)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .req_tag_in  (req_tag_in),
    .out_stall   (out_stall),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .req_busy    (req_busy)
  );

  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // Command cycle then operand-2 cycle; returns right after the push edge.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] op1,
                       input logic [1:0] tag, input logic [31:0] op2);
    req_cmd_in = cmd; req_data_in = op1; req_tag_in = tag;
    tick();
    req_cmd_in = 4'd0; req_data_in = op2; req_tag_in = 2'd0;
    tick();
    req_data_in = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_cmd_in = 4'd0; req_data_in = 32'd0; req_tag_in = 2'd0; out_stall = 1'b0;
    tick(); tick();
    checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL reset_resp: got %0d expected 0", out_resp); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", out_data); end
    checks++; if (out_tag !== 2'd0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", out_tag); end
    checks++; if (req_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", req_busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    issue(4'd1, 32'h56, 2'd1, 32'h103);
    checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL add_early: got %0d expected 0", out_resp); end
    tick();
    checks++; if (out_resp !== 2'd1) begin errors++; $display("FAIL add_resp: got %0d expected 1", out_resp); end
    checks++; if (out_data !== 32'h159) begin errors++; $display("FAIL add_data: got %0h expected 159", out_data); end
    checks++; if (out_tag !== 2'd1) begin errors++; $display("FAIL add_tag: got %0d expected 1", out_tag); end
    tick();
    checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL add_one_cycle: got %0d expected 0", out_resp); end
  endtask

  task automatic test_sub();
    issue(4'd2, 32'h158, 2'd2, 32'h12);
    tick();
    checks++; if (out_resp !== 2'd1 || out_data !== 32'h146 || out_tag !== 2'd2) begin errors++; $display("FAIL sub_ok: got %0d/%0h/%0d expected 1/146/2", out_resp, out_data, out_tag); end
    issue(4'd2, 32'h12, 2'd3, 32'h158);
    tick();
    checks++; if (out_resp !== 2'd2 || out_data !== 32'h0 || out_tag !== 2'd3) begin errors++; $display("FAIL sub_under: got %0d/%0h/%0d expected 2/0/3", out_resp, out_data, out_tag); end
    issue(4'd2, 32'h77, 2'd1, 32'h77);
    tick();
    checks++; if (out_resp !== 2'd1 || out_data !== 32'h0 || out_tag !== 2'd1) begin errors++; $display("FAIL sub_equal: got %0d/%0h/%0d expected 1/0/1", out_resp, out_data, out_tag); end
  endtask

  task automatic test_errors_shifts();
    issue(4'd1, 32'hFFFF_FFFF, 2'd1, 32'h1);
    tick();
    checks++; if (out_resp !== 2'd2 || out_data !== 32'h0 || out_tag !== 2'd1) begin errors++; $display("FAIL add_over: got %0d/%0h/%0d expected 2/0/1", out_resp, out_data, out_tag); end
    issue(4'd5, 32'h1, 2'd2, 32'h21);
    tick();
    checks++; if (out_resp !== 2'd1 || out_data !== 32'h2 || out_tag !== 2'd2) begin errors++; $display("FAIL shl: got %0d/%0h/%0d expected 1/2/2", out_resp, out_data, out_tag); end
    issue(4'd6, 32'h8000_0000, 2'd3, 32'h3F);
    tick();
    checks++; if (out_resp !== 2'd1 || out_data !== 32'h1 || out_tag !== 2'd3) begin errors++; $display("FAIL shr: got %0d/%0h/%0d expected 1/1/3", out_resp, out_data, out_tag); end
    issue(4'd3, 32'h1234, 2'd0, 32'h5);
    tick();
    checks++; if (out_resp !== 2'd2 || out_data !== 32'h0 || out_tag !== 2'd0) begin errors++; $display("FAIL invalid_cmd: got %0d/%0h/%0d expected 2/0/0", out_resp, out_data, out_tag); end
  endtask

  task automatic test_back_to_back();
    req_cmd_in = 4'd1; req_data_in = 32'h1; req_tag_in = 2'd1;
    tick();
    req_cmd_in = 4'd2; req_data_in = 32'h2; req_tag_in = 2'd0;  // command in OP2 must be ignored
    tick();
    req_cmd_in = 4'd1; req_data_in = 32'h10; req_tag_in = 2'd2;
    tick();
    checks++; if (out_resp !== 2'd1 || out_data !== 32'h3 || out_tag !== 2'd1) begin errors++; $display("FAIL b2b_first: got %0d/%0h/%0d expected 1/3/1", out_resp, out_data, out_tag); end
    req_cmd_in = 4'd0; req_data_in = 32'h20; req_tag_in = 2'd0;
    tick();
    req_data_in = 32'h0;
    checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL b2b_gap: got %0d expected 0", out_resp); end
    tick();
    checks++; if (out_resp !== 2'd1 || out_data !== 32'h30 || out_tag !== 2'd2) begin errors++; $display("FAIL b2b_second: got %0d/%0h/%0d expected 1/30/2", out_resp, out_data, out_tag); end
    tick();
    checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL b2b_extra: got %0d expected 0", out_resp); end
  endtask

  task automatic test_stall_fill();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33; exp_data[3] = 32'h44;
    out_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_cmd_in = 4'd1; req_data_in = 32'h10 * (i + 1); req_tag_in = 2'(i);
      tick();
      if (i == 2) begin
        checks++; if (req_busy !== 1'b0) begin errors++; $display("FAIL busy_third: got %0b expected 0", req_busy); end
      end
      if (i == 3) begin
        checks++; if (req_busy !== 1'b1) begin errors++; $display("FAIL busy_fourth: got %0b expected 1", req_busy); end
      end
      req_cmd_in = 4'd0; req_data_in = 32'(i + 1); req_tag_in = 2'd0;
      tick();
    end
    checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL stall_hold: got %0d expected 0", out_resp); end
    req_cmd_in = 4'd1; req_data_in = 32'h777; req_tag_in = 2'd3;
    tick();
    req_cmd_in = 4'd0; req_data_in = 32'h1;
    tick();
    req_data_in = 32'h0;
    checks++; if (req_busy !== 1'b1) begin errors++; $display("FAIL busy_full: got %0b expected 1", req_busy); end
    out_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_resp !== 2'd1 || out_data !== exp_data[i] || out_tag !== 2'(i)) begin errors++; $display("FAIL drain_%0d: got %0d/%0h/%0d expected 1/%0h/%0d", i, out_resp, out_data, out_tag, exp_data[i], i); end
    end
    tick();
    checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL no_fifth: got %0d expected 0", out_resp); end
    checks++; if (req_busy !== 1'b0) begin errors++; $display("FAIL busy_drained: got %0b expected 0", req_busy); end
  endtask

  task automatic test_push_pop();
    out_stall = 1'b1;
    issue(4'd1, 32'h1, 2'd1, 32'h1);
    issue(4'd1, 32'h2, 2'd2, 32'h2);
    issue(4'd1, 32'h3, 2'd3, 32'h3);
    req_cmd_in = 4'd1; req_data_in = 32'h4; req_tag_in = 2'd0;
    tick();
    checks++; if (req_busy !== 1'b1) begin errors++; $display("FAIL pp_busy_op2: got %0b expected 1", req_busy); end
    req_cmd_in = 4'd0; req_data_in = 32'h4; out_stall = 1'b0;
    tick();
    req_data_in = 32'h0;
    checks++; if (out_resp !== 2'd1 || out_data !== 32'h2 || out_tag !== 2'd1) begin errors++; $display("FAIL pp_first: got %0d/%0h/%0d expected 1/2/1", out_resp, out_data, out_tag); end
    checks++; if (req_busy !== 1'b0) begin errors++; $display("FAIL pp_count: busy got %0b expected 0", req_busy); end
    tick();
    checks++; if (out_data !== 32'h4 || out_tag !== 2'd2) begin errors++; $display("FAIL pp_second: got %0h/%0d expected 4/2", out_data, out_tag); end
    tick();
    checks++; if (out_data !== 32'h6 || out_tag !== 2'd3) begin errors++; $display("FAIL pp_third: got %0h/%0d expected 6/3", out_data, out_tag); end
    tick();
    checks++; if (out_resp !== 2'd1 || out_data !== 32'h8 || out_tag !== 2'd0) begin errors++; $display("FAIL pp_fourth: got %0d/%0h/%0d expected 1/8/0", out_resp, out_data, out_tag); end
    tick();
    checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL pp_empty: got %0d expected 0", out_resp); end
  endtask

  task automatic test_reset_in_op2();
    out_stall = 1'b1;
    issue(4'd1, 32'h5, 2'd1, 32'h5);
    issue(4'd1, 32'h6, 2'd2, 32'h6);
    issue(4'd1, 32'h7, 2'd3, 32'h7);
    req_cmd_in = 4'd1; req_data_in = 32'h100; req_tag_in = 2'd0; out_stall = 1'b0;
    tick();
    req_cmd_in = 4'd0; req_data_in = 32'h200; out_stall = 1'b1;
    checks++; if (out_resp !== 2'd1 || out_data !== 32'hA) begin errors++; $display("FAIL rst_pre: got %0d/%0h expected 1/a", out_resp, out_data); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_resp !== 2'd0 || out_data !== 32'h0 || out_tag !== 2'd0) begin errors++; $display("FAIL rst_async_out: got %0d/%0h/%0d expected 0/0/0", out_resp, out_data, out_tag); end
    checks++; if (req_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %0b expected 0", req_busy); end
    req_data_in = 32'h0;
    tick();
    reset = 1'b0; out_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_resp !== 2'd0) begin errors++; $display("FAIL rst_ghost_%0d: got %0d expected 0", i, out_resp); end
    end
    issue(4'd1, 32'h1, 2'd2, 32'h1);
    tick();
    checks++; if (out_resp !== 2'd1 || out_data !== 32'h2 || out_tag !== 2'd2) begin errors++; $display("FAIL rst_after_add: got %0d/%0h/%0d expected 1/2/2", out_resp, out_data, out_tag); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_errors_shifts();
    test_back_to_back();
    test_stall_fill();
    test_push_pop();
    test_reset_in_op2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
